muldiv_unit: RTL

Iterative multiply/divide unit for the execute stage, alongside the ALU. It implements MIPS MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers read by MFHI/MFLO and written by MTHI/MTLO. Each operation is radix-2, one bit per cycle. Every iteration's add or trial subtraction runs through a single (width+1)-bit `au` instance. The pipeline stalls on `busy`.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Bus between the execute stage and the multiply/divide unit: operation request,
// MTHI/MTLO writes, and the registered HI/LO/status outputs.
interface muldiv_unit_if #(
  parameter int width = 32
);
  logic             start;
  logic [1:0]       op;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [width-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [width-1:0] hi;
  logic [width-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shared (width+1)-bit add/subtract unit serves every iteration.
module muldiv_au #(
  parameter int w = 33
) (
  input  logic [w-1:0] x_i,
  input  logic [w-1:0] y_i,
  input  logic         sub_i,
  output logic [w-1:0] r_o
);
  assign r_o = sub_i ? (x_i - y_i) : (x_i + y_i);
endmodule

// Handshake: start is sampled only in IDLE; busy is high for the width+1 cycles
// of RUN and FIX; done pulses for one cycle with busy low and fresh hi/lo.
module muldiv_unit #(
  parameter int width = 32
) (
  input  logic           clock,
  input  logic           reset,
  muldiv_unit_if.slave   bus,
  output logic [1:0]     state_o
);
  localparam int W2 = 2 * width;
  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             div_q, div_d;
  logic [width-1:0] opa_q, opa_d;
  logic [width-1:0] opb_q, opb_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             bzero_q, bzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [width-1:0] hi_q, hi_d;
  logic [width-1:0] lo_q, lo_d;

  logic             neg_a, neg_b;
  logic [width-1:0] mag_a, mag_b;
  logic [width:0]   rem_sh;
  logic [width:0]   au_x, au_y, au_r;
  logic             au_sub;
  logic [W2-1:0]    prod_neg;
  logic [width-1:0] quot_neg, rem_negv;

  assign neg_a    = bus.op[0] & bus.a[width-1];
  assign neg_b    = bus.op[0] & bus.b[width-1];
  assign mag_a    = -bus.a;
  assign mag_b    = -bus.b;
  // Divide: the dividend enters the remainder one bit per cycle from opa_q's MSB.
  assign rem_sh   = {acc_q[W2-1:width], opa_q[width-1]};
  assign prod_neg = -acc_q;
  assign quot_neg = -acc_q[width-1:0];
  assign rem_negv = -acc_q[W2-1:width];

  muldiv_au #(.w(width + 1)) au (
    .x_i   (au_x),
    .y_i   (au_y),
    .sub_i (au_sub),
    .r_o   (au_r)
  );

  always_comb begin
    au_x   = {1'b0, acc_q[W2-1:width]};
    au_y   = opb_q[0] ? {1'b0, opa_q} : '0;
    au_sub = 1'b0;
    if (div_q) begin
      au_x   = rem_sh;
      au_y   = {1'b0, opb_q};
      au_sub = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_d     = bus.op[1];
          opa_d     = neg_a ? mag_a : bus.a;
          opb_d     = neg_b ? mag_b : bus.b;
          res_neg_d = neg_a ^ neg_b;
          rem_neg_d = neg_a;
          bzero_d   = bus.op[1] & (bus.b == '0);
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      RUN: begin
        if (div_q) begin
          acc_d = {(au_r[width] ? rem_sh[width-1:0] : au_r[width-1:0]),
                   acc_q[width-2:0], ~au_r[width]};
          opa_d = opa_q << 1;
        end else begin
          acc_d = {au_r, acc_q[width-1:1]};
          opb_d = opb_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          lo_d = bzero_q ? '1 : (res_neg_q ? quot_neg : acc_q[width-1:0]);
          hi_d = rem_neg_q ? rem_negv : acc_q[W2-1:width];
        end else begin
          {hi_d, lo_d} = res_neg_q ? prod_neg : acc_q;
        end
        dbz_d   = div_q & bzero_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign state_o         = state_q;
endmodule
